// File: rtl/local_ni.sv
// local_ni: PE <-> router local-port network interface (credit-based injection, FWFT ejection FIFO).
// Define LOCAL_NI_STATS_EN to add 16-bit tx/rx flit counters (tx_cnt_o, rx_cnt_o).
module local_ni #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 28,
    parameter int unsigned CREDITS  = 4,
    parameter int unsigned EJ_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inj_valid_i,
    output logic                     inj_ready_o,
    input  logic [ADDR_W-1:0]        inj_dest_i,
    input  logic [DATA_W-1:0]        inj_data_i,
    output logic [ADDR_W+DATA_W-1:0] flit_o,
    output logic                     flit_valid_o,
    input  logic                     credit_i,
    input  logic [ADDR_W+DATA_W-1:0] flit_i,
    input  logic                     flit_valid_i,
    output logic                     credit_o,
    output logic                     ej_valid_o,
    input  logic                     ej_ready_i,
    output logic [ADDR_W-1:0]        ej_dest_o,
    output logic [DATA_W-1:0]        ej_data_o,
    output logic                     ovf_err_o,
    output logic                     crd_err_o
`ifdef LOCAL_NI_STATS_EN
    ,
    output logic [15:0]              tx_cnt_o,
    output logic [15:0]              rx_cnt_o
`endif
);

    localparam int unsigned FLIT_W = ADDR_W + DATA_W;
    localparam int unsigned CRD_W  = $clog2(CREDITS + 1);
    localparam int unsigned PTR_W  = $clog2(EJ_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    logic [CRD_W-1:0]  crd_q, crd_d;
    logic [FLIT_W-1:0] flit_q, flit_d;
    logic              flit_valid_q, flit_valid_d;
    logic              crd_err_q, crd_err_d;

    logic [FLIT_W-1:0] mem_q [EJ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              credit_q, credit_d;
    logic              ovf_q, ovf_d;

    logic accept, pop, full, push_ok;

    assign inj_ready_o = (crd_q != '0);
    assign accept      = inj_valid_i && inj_ready_o;
    assign pop         = (count_q != '0) && ej_ready_i;
    assign full        = (count_q == CNT_W'(EJ_DEPTH));
    assign push_ok     = flit_valid_i && (!full || pop);

    // Injection: flit register, credit counter with saturation on spurious credit.
    always_comb begin
        flit_d       = flit_q;
        flit_valid_d = accept;
        crd_d        = crd_q;
        crd_err_d    = crd_err_q;
        if (accept) begin
            flit_d = {inj_dest_i, inj_data_i};
        end
        if (accept && !credit_i) begin
            crd_d = crd_q - CRD_W'(1);
        end else if (credit_i && !accept) begin
            if (crd_q == CRD_W'(CREDITS)) begin
                crd_err_d = 1'b1;
            end else begin
                crd_d = crd_q + CRD_W'(1);
            end
        end
    end

    // Ejection FIFO pointer/count bookkeeping; a full push is only taken alongside a pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        credit_d = pop;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (flit_valid_i && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crd_q        <= CRD_W'(CREDITS);
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
            crd_err_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            credit_q     <= 1'b0;
            ovf_q        <= 1'b0;
            for (int unsigned i = 0; i < EJ_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            crd_q        <= crd_d;
            flit_q       <= flit_d;
            flit_valid_q <= flit_valid_d;
            crd_err_q    <= crd_err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            credit_q     <= credit_d;
            ovf_q        <= ovf_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= flit_i;
            end
        end
    end

    assign flit_o       = flit_q;
    assign flit_valid_o = flit_valid_q;
    assign crd_err_o    = crd_err_q;
    assign credit_o     = credit_q;
    assign ovf_err_o    = ovf_q;
    assign ej_valid_o   = (count_q != '0);
    assign ej_dest_o    = mem_q[rd_ptr_q][FLIT_W-1:DATA_W];
    assign ej_data_o    = mem_q[rd_ptr_q][DATA_W-1:0];

`ifdef LOCAL_NI_STATS_EN
    logic [15:0] tx_q, rx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            if (accept) begin
                tx_q <= tx_q + 16'(1);
            end
            if (push_ok) begin
                rx_q <= rx_q + 16'(1);
            end
        end
    end

    assign tx_cnt_o = tx_q;
    assign rx_cnt_o = rx_q;
`endif

endmodule

// File: doc/local_ni.md
# local_ni

Local network interface between a processing element (PE) and a router's local port. The injection side packs PE requests into flits and drives the router's local input under credit-based flow control. The ejection side buffers flits leaving the router's local output in a FIFO and returns one credit per freed slot. Each mesh node has one `local_ni` next to its router.

## Interface
Parameters:
- `ADDR_W`, 4: destination address width (`{y, x}`, same format as the router node address).
- `DATA_W`, 28: payload width. Flit width is `FLIT_W = ADDR_W + DATA_W`.
- `CREDITS`, 4: depth of the router's local input buffer. Also the initial injection credit count.
- `EJ_DEPTH`, 4: ejection FIFO depth. Must be a power of two and ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inj_valid_i`  in  1  PE has a request.
- `inj_ready_o`  out  1  NI accepts the request this cycle.
- `inj_dest_i`  in  ADDR_W  destination node address.
- `inj_data_i`  in  DATA_W  payload.
- `flit_o`  out  FLIT_W  flit to router local input, `{dest, data}`.
- `flit_valid_o`  out  1  one-cycle push strobe to router local input.
- `credit_i`  in  1  one-cycle pulse: router freed one slot of its local input buffer.
- `flit_i`  in  FLIT_W  flit from router local output.
- `flit_valid_i`  in  1  router local output valid.
- `credit_o`  out  1  one-cycle pulse to the router's local-port credit counter.
- `ej_valid_o`  out  1  ejection FIFO not empty.
- `ej_ready_i`  in  1  PE consumes the head flit.
- `ej_dest_o`  out  ADDR_W  head flit destination field.
- `ej_data_o`  out  DATA_W  head flit payload.
- `ovf_err_o`  out  1  sticky error: a flit arrived while the ejection FIFO was full.
- `crd_err_o`  out  1  sticky error: credit returned while the credit counter was at `CREDITS`.

## Operation
- **Injection credit counter** `crd`:
  - Width is `$clog2(CREDITS+1)`; reset value is `CREDITS`.
  - `inj_ready_o = (crd != 0)`, combinational from the register only, with no path from `inj_valid_i`.
  - Accept condition: `inj_valid_i && inj_ready_o`. On accept, register `flit_o <= {inj_dest_i, inj_data_i}` and set `flit_valid_o <= 1`; otherwise `flit_valid_o <= 0`.
  - `flit_o` holds its last value when not valid.
  - Counter update:
    - accept only: `crd - 1`;
    - `credit_i` only: `crd + 1`;
    - both: unchanged.
  - `credit_i` with `crd == CREDITS` and no accept in the same cycle: `crd` saturates at `CREDITS` and `crd_err_o` is set.
- **Ejection FIFO**:
  - Circular buffer with read and write pointers of `$clog2(EJ_DEPTH)` bits and a count of `$clog2(EJ_DEPTH)+1` bits.
  - Push on `flit_valid_i`. Pop on `ej_valid_o && ej_ready_i`.
  - `ej_valid_o = (count != 0)`. `ej_dest_o` and `ej_data_o` show the head entry as a first-word fall-through read.
  - Pointers wrap modulo `EJ_DEPTH`.
  - Push while full with no pop in the same cycle: the flit is dropped, FIFO state is unchanged, and `ovf_err_o` is set.
  - Push while full with a pop in the same cycle: accepted, and count stays at `EJ_DEPTH`.
- **Credit return**: each pop registers `credit_o <= 1` for exactly one cycle; otherwise `credit_o` is 0. The router's local-port credit counter must be initialised to `EJ_DEPTH`.
- **Error flags**: `ovf_err_o` and `crd_err_o` clear only on `rst`.

## Timing
- **Reset values**:
  - outputs: `inj_ready_o = 1` (requires `CREDITS ≥ 1`); `flit_valid_o`, `credit_o`, `ej_valid_o`, `ovf_err_o`, `crd_err_o` are 0; `flit_o`, `ej_dest_o`, `ej_data_o` are 0;
  - internal state: `crd = CREDITS`, FIFO empty.
- **Injection**:
  - Latency is 1 cycle from the accept edge to `flit_valid_o` high.
  - Back-to-back accepts give one flit per cycle while credits remain.
  - `inj_ready_o` drops in the cycle after the accept that consumed the last credit.
- **Ejection**:
  - A flit pushed at edge N is visible at the outputs with `ej_valid_o = 1` after edge N. There is no same-cycle bypass.
  - Pop at edge N gives `credit_o` high from N to N+1.
- **Reset mid-operation**: asynchronous clear of all state. In-flight FIFO contents and credits are discarded, and the counter reloads to `CREDITS`.

## Configuration
- `LOCAL_NI_STATS_EN` defined:
  - adds output ports `tx_cnt_o` and `rx_cnt_o`, 16 bits each, reset to 0;
  - `tx_cnt_o` increments on each injection accept; `rx_cnt_o` increments on each accepted ejection push;
  - both counters wrap from 0xFFFF to 0x0000.
- Macro undefined: the ports and counters are absent, and all other behaviour is identical.

## Test plan
- **Reset**: assert `rst` asynchronously between clock edges. All outputs reach their reset values immediately, `inj_ready_o = 1`, and the errors are 0.
- **Credit exhaustion**: with `CREDITS = 4`, hold `inj_valid_i = 1`, dest 0x5, data 0x1..0x6, and no `credit_i`.
  - Four flits appear on consecutive cycles: `flit_o = 0x5000_0001` through `0x5000_0004`.
  - `inj_ready_o = 0` after the fourth accept.
  - A single `credit_i` pulse lets flit 0x5000_0005 through one cycle after acceptance.
- **Simultaneous accept and credit at `crd = 1`**: `crd` stays 1, `inj_ready_o` stays 1, and `crd_err_o` stays 0.
- **Ejection fill and overflow**: push 5 flits with `ej_ready_i = 0` and `EJ_DEPTH = 4`.
  - The first 4 are retained.
  - The fifth sets `ovf_err_o = 1`.
  - The head remains flit 1.
- **Full push with pop**: with the FIFO full, hold `ej_ready_i = 1` during a push.
  - The head advances and the new flit is stored.
  - `credit_o` pulses exactly once per pop.
  - Drain order is preserved across pointer wrap (check 10 sequential flits).
- **Stats** (with `LOCAL_NI_STATS_EN`):
  - After 65 537 injection accepts, `tx_cnt_o = 1`.
  - `rx_cnt_o` is unchanged by dropped overflow flits.
